// File: rtl/delta_integ.sv
// delta_integ: rebuilds an absolute sample stream from first differences.
// A frame starts with an absolute seed sample and continues with signed deltas
// that are summed into a running total. Output appears exactly one cycle after
// each accepted input. Signed overflow raises a sticky per-frame flag.
// Optional build macro DELTA_INTEG_SAT_EN: clamp overflowing sums instead of
// letting them wrap modulo 2^BIT.
module delta_integ #(
    parameter int unsigned BIT       = 32,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           data_in_valid,
    input  logic           frame_start,
    input  logic [BIT-1:0] D_in,
    output logic           data_out_valid,
    output logic [BIT-1:0] C_out,
    output logic           frame_done,
    output logic           ovf
);

    // Wide enough to hold FRAME_LEN itself, so the count cannot wrap in a frame.
    localparam int unsigned CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic           state_q, state_d;
    logic [BIT-1:0] acc_q, acc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [BIT-1:0] c_out_q, c_out_d;
    logic           dv_q, dv_d;
    logic           fd_q, fd_d;
    logic           ovf_q, ovf_d;

    logic [BIT-1:0] add_sum;
    logic           add_ovf;
    logic [BIT-1:0] add_res;
    logic [CW-1:0]  count_inc;

    // Signed add with overflow: equal-sign operands giving an opposite-sign sum.
    always_comb begin
        add_sum = acc_q + D_in;
        add_ovf = (acc_q[BIT-1] == D_in[BIT-1]) && (add_sum[BIT-1] != acc_q[BIT-1]);
    end

`ifdef DELTA_INTEG_SAT_EN
    localparam logic [BIT-1:0] SAT_MAX = {1'b0, {(BIT-1){1'b1}}};
    localparam logic [BIT-1:0] SAT_MIN = {1'b1, {(BIT-1){1'b0}}};

    // Clamp toward the sign shared by both operands when the sum overflows.
    always_comb begin
        add_res = add_sum;
        if (add_ovf) begin
            add_res = acc_q[BIT-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    // Two's-complement wrap; overflow is only flagged.
    always_comb begin
        add_res = add_sum;
    end
`endif

    // Frame sequencing: seed, accumulate, close the frame at FRAME_LEN outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        c_out_d   = c_out_q;
        dv_d      = 1'b0;
        fd_d      = 1'b0;
        ovf_d     = ovf_q;
        count_inc = count_q + CW'(1);

        if (data_in_valid) begin
            if (frame_start) begin
                // A seed is accepted in any state and abandons a running frame.
                acc_d   = D_in;
                c_out_d = D_in;
                dv_d    = 1'b1;
                count_d = CW'(1);
                ovf_d   = 1'b0;
                if (LAST_CNT == CW'(1)) begin
                    fd_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end else if (state_q == S_RUN) begin
                acc_d   = add_res;
                c_out_d = add_res;
                dv_d    = 1'b1;
                count_d = count_inc;
                ovf_d   = ovf_q | add_ovf;
                if (count_inc == LAST_CNT) begin
                    fd_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            // Deltas arriving in IDLE are dropped.
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            c_out_q <= '0;
            dv_q    <= 1'b0;
            fd_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            c_out_q <= c_out_d;
            dv_q    <= dv_d;
            fd_q    <= fd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out_valid = dv_q;
    assign C_out          = c_out_q;
    assign frame_done     = fd_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_delta_integ.sv
// Directed bench for delta_integ: a FRAME_LEN=4 instance for the main checks
// and a FRAME_LEN=1 instance sharing the same stimulus for single-sample frames.
module tb_delta_integ;

    logic        clk;
    logic        rst_n;
    logic        data_in_valid;
    logic        frame_start;
    logic [31:0] D_in;

    logic        dv4, fd4, ovf4;
    logic [31:0] c4;
    logic        dv1, fd1, ovf1;
    logic [31:0] c1;

    int n_checks = 0;
    int n_errors = 0;

    delta_integ #(.BIT(32), .FRAME_LEN(4)) u_dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in_valid  (data_in_valid),
        .frame_start    (frame_start),
        .D_in           (D_in),
        .data_out_valid (dv4),
        .C_out          (c4),
        .frame_done     (fd4),
        .ovf            (ovf4)
    );

    delta_integ #(.BIT(32), .FRAME_LEN(1)) u_dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in_valid  (data_in_valid),
        .frame_start    (frame_start),
        .D_in           (D_in),
        .data_out_valid (dv1),
        .C_out          (c1),
        .frame_done     (fd1),
        .ovf            (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one input cycle at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic v, input logic fs, input logic [31:0] d);
        @(negedge clk);
        data_in_valid = v;
        frame_start   = fs;
        D_in          = d;
        @(posedge clk);
        #1;
    endtask

    task automatic out4(input string tag, input logic dv, input logic [31:0] c, input logic fd);
        check_eq({tag, "_dv"}, 32'(dv4), 32'(dv));
        check_eq({tag, "_c"},  c4, c);
        check_eq({tag, "_fd"}, 32'(fd4), 32'(fd));
    endtask

    logic [31:0] seq_in  [4];
    logic [31:0] seq_exp [4];
    logic [31:0] ovf_exp_pos;
    logic [31:0] ovf_exp_neg;

    initial begin
        rst_n = 1'b0;
        data_in_valid = 1'b0;
        frame_start = 1'b0;
        D_in = '0;
        seq_in  = '{32'd100, 32'd5, -32'sd3, 32'd10};
        seq_exp = '{32'd100, 32'd105, 32'd102, 32'd112};
`ifdef DELTA_INTEG_SAT_EN
        ovf_exp_pos = 32'h7FFF_FFFF;
        ovf_exp_neg = 32'h8000_0000;
`else
        ovf_exp_pos = 32'h8000_0010;
        ovf_exp_neg = 32'h7FFF_FFFF;
`endif

        repeat (2) @(posedge clk);
        #1;
        out4("reset", 1'b0, 32'd0, 1'b0);
        check_eq("reset_ovf", 32'(ovf4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, back to back.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), seq_in[i]);
            out4($sformatf("basic%0d", i), 1'b1, seq_exp[i], (i == 3));
        end
        step(1'b0, 1'b0, 32'd0);
        out4("basic_idle", 1'b0, 32'd112, 1'b0);
        // Back in IDLE: a delta is dropped.
        step(1'b1, 1'b0, 32'd7);
        out4("drop_idle", 1'b0, 32'd112, 1'b0);

        // Same frame with 3-cycle gaps.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), seq_in[i]);
            out4($sformatf("gap%0d", i), 1'b1, seq_exp[i], (i == 3));
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b0, 32'hDEAD_BEEF);
                out4($sformatf("gap%0d_hold%0d", i, g), 1'b0, seq_exp[i], 1'b0);
            end
        end

        // Reseed mid-frame abandons it without frame_done; count restarts.
        step(1'b1, 1'b1, 32'd1);
        out4("rs_seed1", 1'b1, 32'd1, 1'b0);
        step(1'b1, 1'b0, 32'd1);
        out4("rs_d1", 1'b1, 32'd2, 1'b0);
        step(1'b1, 1'b1, 32'd50);
        out4("rs_seed50", 1'b1, 32'd50, 1'b0);
        step(1'b1, 1'b0, 32'd1);
        out4("rs_51", 1'b1, 32'd51, 1'b0);
        step(1'b1, 1'b0, 32'd1);
        out4("rs_52", 1'b1, 32'd52, 1'b0);
        step(1'b1, 1'b0, 32'd1);
        out4("rs_53", 1'b1, 32'd53, 1'b1);

        // Positive overflow, stickiness, cleared by the next seed.
        step(1'b1, 1'b1, 32'h7FFF_FFF0);
        check_eq("ovf_seed_c", c4, 32'h7FFF_FFF0);
        check_eq("ovf_seed_flag", 32'(ovf4), 32'd0);
        step(1'b1, 1'b0, 32'h0000_0020);
        check_eq("ovf_pos_c", c4, ovf_exp_pos);
        check_eq("ovf_pos_flag", 32'(ovf4), 32'd1);
        step(1'b1, 1'b0, 32'd0);
        check_eq("ovf_sticky_c", c4, ovf_exp_pos);
        check_eq("ovf_sticky_flag", 32'(ovf4), 32'd1);
        step(1'b0, 1'b0, 32'd0);
        check_eq("ovf_hold_flag", 32'(ovf4), 32'd1);
        step(1'b1, 1'b1, 32'd5);
        check_eq("ovf_clr_c", c4, 32'd5);
        check_eq("ovf_clr_flag", 32'(ovf4), 32'd0);

        // Negative overflow, then reset mid-frame after 2 samples.
        step(1'b1, 1'b1, 32'h8000_0000);
        step(1'b1, 1'b0, 32'hFFFF_FFFF);
        out4("ovf_neg", 1'b1, ovf_exp_neg, 1'b0);
        check_eq("ovf_neg_flag", 32'(ovf4), 32'd1);
        @(negedge clk);
        data_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        out4("async_rst", 1'b0, 32'd0, 1'b0);
        check_eq("async_rst_ovf", 32'(ovf4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'd9);
        out4("post_rst_drop", 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'd9);
        out4("post_rst_seed", 1'b1, 32'd9, 1'b0);

        // FRAME_LEN=1 instance: every seed closes its frame, deltas are dropped.
        step(1'b1, 1'b1, 32'd3);
        check_eq("fl1_3_dv", 32'(dv1), 32'd1);
        check_eq("fl1_3_c", c1, 32'd3);
        check_eq("fl1_3_fd", 32'(fd1), 32'd1);
        step(1'b1, 1'b1, 32'd4);
        check_eq("fl1_4_dv", 32'(dv1), 32'd1);
        check_eq("fl1_4_c", c1, 32'd4);
        check_eq("fl1_4_fd", 32'(fd1), 32'd1);
        step(1'b1, 1'b0, 32'd6);
        check_eq("fl1_drop_dv", 32'(dv1), 32'd0);
        check_eq("fl1_drop_c", c1, 32'd4);
        check_eq("fl1_drop_fd", 32'(fd1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
